// File: rtl/gf8_pkg.sv
// gf8_pkg
//   Shared definitions for the GF(2^8) inverter arbiter.
//   GF8_W    : field element width (8)
//   gf8_t    : one field element
//   state_e  : result-register state (IDLE = empty, FULL = holding a result)
//   gf8_mul  : multiply in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1
package gf8_pkg;

  localparam int GF8_W = 8;

  typedef logic [GF8_W-1:0] gf8_t;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  // Shift-and-add multiply; the 0x1B fold reduces x^8 back into the field.
  function automatic gf8_t gf8_mul(input gf8_t a, input gf8_t b);
    gf8_t p;
    gf8_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < GF8_W; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[GF8_W-2:0], 1'b0} ^ (aa[GF8_W-1] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/invert8.sv
// invert8
//   Purely combinational GF(2^8) multiplicative inverse, AES polynomial 0x11B.
//   a : operand
//   y : inverse of a; a = 0x00 yields 0x00
module invert8
  import gf8_pkg::*;
(
  input  gf8_t a,
  output gf8_t y
);

  // a^-1 = a^254 in GF(2^8). Each step r <- r^2 * a walks the exponent
  // 1 -> 3 -> 7 -> 15 -> 31 -> 63 -> 127; a final squaring gives 254.
  // 0^254 = 0, so the zero operand needs no special case.
  always_comb begin
    gf8_t r;
    r = a;
    for (int i = 0; i < 6; i++) begin
      r = gf8_mul(gf8_mul(r, r), a);
    end
    y = gf8_mul(r, r);
  end

endmodule

// File: rtl/gf8_inv_arbiter.sv
// gf8_inv_arbiter
//   N_REQ requesters share one GF(2^8) inverter through a round-robin arbiter
//   and a single result register.
//
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   req_valid  : per-requester operand present
//   req_data   : operand i in bits [8i+7:8i]
//   req_ready  : one-hot grant (or zero), combinational
//   rsp_valid  : result register holds a valid inverse
//   rsp_data   : inverse of the accepted operand
//   rsp_id     : index of the requester that supplied it
//   rsp_ready  : consumer accepts the result
//   dbg_state  : current result-register state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A requester keeps req_valid and its operand stable until it sees
// req_ready; the block never latches an ungranted operand. rsp_valid, rsp_data
// and rsp_id stay stable while rsp_valid is high and rsp_ready is low.
module gf8_inv_arbiter
  import gf8_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [GF8_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output gf8_t                   rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   rsp_ready,
  output state_e                 dbg_state
);

  state_e          state_q,      state_d;
  logic            rsp_valid_q,  rsp_valid_d;
  gf8_t            rsp_data_q,   rsp_data_d;
  logic [ID_W-1:0] rsp_id_q,     rsp_id_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;

  logic            slot_free;
  logic            grant_found;
  logic            grant_en;
  logic [ID_W-1:0] grant_idx;
  gf8_t            operand;
  gf8_t            inv_out;

  // The result slot is free when empty, or when the held result leaves on
  // this very edge (drain and refill in the same cycle).
  assign slot_free = (state_q == IDLE) || ((state_q == FULL) && rsp_ready);

  // Round-robin search starting one past the last grant. The sum is at most
  // 2*N_REQ-1, so one conditional subtraction performs the modulo.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, last_grant_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      cand = sum[ID_W-1:0];
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_en = grant_found && slot_free && !rst;

  // Operand mux and one-hot ready, unrolled so every select is constant.
  always_comb begin
    operand   = '0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        operand      = req_data[i*GF8_W +: GF8_W];
        req_ready[i] = grant_en;
      end
    end
  end

  invert8 u_invert8 (
    .a (operand),
    .y (inv_out)
  );

  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    if (grant_en) begin
      state_d      = FULL;
      rsp_valid_d  = 1'b1;
      rsp_data_d   = inv_out;
      rsp_id_d     = grant_idx;
      last_grant_d = grant_idx;
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
    end
  end

  // last_grant resets to N_REQ-1 so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      last_grant_q <= ID_W'(N_REQ - 1);
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gf8_inv_arbiter.sv
// tb_gf8_inv_arbiter
//   Self-checking bench for gf8_inv_arbiter with N_REQ = 4. A negedge
//   scoreboard predicts grants and results with its own round-robin and
//   brute-force inverse model; per-scenario tasks add directed checks.
module tb_gf8_inv_arbiter;
  import gf8_pkg::*;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int W     = ID_W + 8;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [31:0]  req_data  = '0;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  gf8_t         rsp_data;
  logic [1:0]   rsp_id;
  logic         rsp_ready = 1'b0;
  state_e       dbg_state;

  always #5 clk = ~clk;

  gf8_inv_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_pop    = 0;

  logic [W-1:0] exp_q[$];
  logic         model_full = 1'b0;
  logic [1:0]   model_last = 2'd3;

  // ---------------- reference model ----------------
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] tb_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 1; b < 256; b++) if (tb_mul(a, 8'(b)) == 8'h01) r = 8'(b);
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : scoreboard
    logic [3:0]   exp_rdy;
    logic [1:0]   g;
    logic [1:0]   c;
    logic         gfound;
    logic [W-1:0] e;
    if (rst) begin
      n_checks++;
      if (req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL sb_ready_in_reset: got %b expected 0000", req_ready);
      end
      exp_q.delete();
      model_full = 1'b0;
      model_last = 2'd3;
    end else begin
      gfound = 1'b0;
      g      = 2'd0;
      if (!model_full || rsp_ready) begin
        for (int k = 1; k <= N_REQ; k++) begin
          c = model_last + 2'(k);
          if (!gfound && req_valid[c]) begin
            gfound = 1'b1;
            g      = c;
          end
        end
      end
      exp_rdy = gfound ? (4'b0001 << g) : 4'b0000;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL sb_req_ready: got %b expected %b", req_ready, exp_rdy);
      end
      n_checks++;
      if (rsp_valid !== model_full) begin
        n_fail++;
        $display("FAIL sb_rsp_valid: got %b expected %b", rsp_valid, model_full);
      end
      if (rsp_valid === 1'b1 && rsp_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_rsp: got id=%0d data=%h expected none", rsp_id, rsp_data);
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          if ({rsp_id, rsp_data} !== e) begin
            n_fail++;
            $display("FAIL sb_rsp: got id=%0d data=%h expected id=%0d data=%h",
                     rsp_id, rsp_data, e[W-1:8], e[7:0]);
          end
        end
      end
      if (gfound) begin
        exp_q.push_back({g, tb_inv(req_data[8*g +: 8])});
        n_push++;
        model_last = g;
      end
      model_full = gfound | (model_full & !rsp_ready);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step();
    rst       = 1'b1;
    req_valid = 4'b1111;
    step();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b d=%h id=%0d st=%0d expected 0 00 0 IDLE",
               rsp_valid, rsp_data, rsp_id, dbg_state);
    end
    step();
    req_valid = '0;
    rst       = 1'b0;
  endtask

  task automatic test_single();
    step();
    req_valid     = 4'b0001;
    req_data[7:0] = 8'h02;
    rsp_ready     = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_grant: got %b expected 0001", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h8D || rsp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL single_rsp: got v=%b d=%h id=%0d expected 1 8d 0", rsp_valid, rsp_data, rsp_id);
    end
    step();
  endtask

  task automatic test_contend();
    logic [7:0] exp_res [5];
    exp_res = '{8'hF6, 8'hCA, 8'h1C, 8'h00, 8'hF6};
    do_reset();
    req_data  = {8'h00, 8'hFF, 8'h53, 8'h03};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== (4'b0001 << (c % 4))) begin
        n_fail++;
        $display("FAIL contend_grant%0d: got %b expected %b", c, req_ready, 4'b0001 << (c % 4));
      end
      if (c > 0) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_res[c-1] || rsp_id !== 2'((c - 1) % 4)) begin
          n_fail++;
          $display("FAIL contend_rsp%0d: got v=%b d=%h id=%0d expected 1 %h %0d",
                   c - 1, rsp_valid, rsp_data, rsp_id, exp_res[c-1], (c - 1) % 4);
        end
      end
      step();
    end
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp_res[4] || rsp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL contend_rsp4: got v=%b d=%h id=%0d expected 1 f6 0", rsp_valid, rsp_data, rsp_id);
    end
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_data  = {8'h00, 8'hFF, 8'h53, 8'h02};
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    step();
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_data !== 8'h8D || rsp_id !== 2'd0
          || dbg_state !== FULL) begin
        n_fail++;
        $display("FAIL stall%0d: got rdy=%b v=%b d=%h id=%0d expected 0000 1 8d 0",
                 c, req_ready, rsp_valid, rsp_data, rsp_id);
      end
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL stall_release_grant: got %b expected 0010", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hCA || rsp_id !== 2'd1) begin
      n_fail++;
      $display("FAIL stall_release_rsp: got v=%b d=%h id=%0d expected 1 ca 1", rsp_valid, rsp_data, rsp_id);
    end
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    req_data  = {8'h10, 8'h20, 8'h30, 8'h40};
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_first: got %b expected 1000", req_ready);
    end
    step();
    req_valid = 4'b1001;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_to_0: got %b expected 0001", req_ready);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_to_3: got %b expected 1000", req_ready);
    end
    step();
    req_valid = '0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data  = {8'h00, 8'hFF, 8'h53, 8'h03};
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || dbg_state !== FULL) begin
      n_fail++;
      $display("FAIL midrst_full: got v=%b st=%0d expected 1 FULL", rsp_valid, dbg_state);
    end
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || dbg_state !== IDLE || rsp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_cleared: got v=%b st=%0d d=%h expected 0 IDLE 00", rsp_valid, dbg_state, rsp_data);
    end
    step();
    rst       = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_regrant: got rdy=%b v=%b expected 0001 0", req_ready, rsp_valid);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (rsp_data !== 8'hF6 || rsp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_rsp: got d=%h id=%0d expected f6 0", rsp_data, rsp_id);
    end
    step();
  endtask

  task automatic test_exhaustive();
    int  r;
    int  cyc;
    bit  done;
    int  push0;
    int  pop0;
    do_reset();
    push0 = n_push;
    pop0  = n_pop;
    for (int op = 0; op < 256; op++) begin
      r              = $urandom_range(0, N_REQ - 1);
      req_data       = $urandom();
      req_data[8*r +: 8] = 8'(op);
      req_valid      = 4'b0001 << r;
      rsp_ready      = ($urandom_range(0, 3) != 0);
      done           = 1'b0;
      cyc            = 0;
      while (!done && cyc < 64) begin
        @(negedge clk);
        if (req_ready[r]) done = 1'b1;
        step();
        cyc++;
        if (!done) rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (!done) begin
        n_checks++;
        n_fail++;
        $display("FAIL exh_timeout: operand %h requester %0d never granted", op, r);
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      step();
      cyc++;
    end
    step();
    n_checks++;
    if ((n_push - push0) !== 256 || (n_pop - pop0) !== 256 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL exh_count: got pushed=%0d popped=%0d left=%0d expected 256 256 0",
               n_push - push0, n_pop - pop0, exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_contend();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
